// File: rtl/serial_sub32.sv
// Bit-serial subtractor: computes a-b LSB first, one bit per clock, with final borrow.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_d;
   logic [CW-1:0]    r_cnt;
   logic             r_br;
   logic             r_bout;
   logic             w_load;
   logic             w_last;
   logic             w_diff;
   logic             w_br_next;
   logic [WIDTH-1:0] w_res_next;

   // Operands are only sampled outside RUN; a start during RUN is dropped.
   assign w_load     = ((r_state == StIdle) || (r_state == StDone)) && start;
   assign w_last     = (r_cnt == LastBit);
   assign w_diff     = r_a[0] ^ r_b[0] ^ r_br;
   assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
   assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (start) w_state_next = StRun;
         StRun:   if (w_last) w_state_next = StDone;
         StDone:  w_state_next = start ? StRun : StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_d    <= '0;
         r_cnt  <= '0;
         r_br   <= 1'b0;
         r_bout <= 1'b0;
      end else if (w_load) begin
         r_a   <= a;
         r_b   <= b;
         r_res <= '0;
         r_cnt <= '0;
         r_br  <= 1'b0;
      end else if (r_state == StRun) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= w_res_next;
         r_br  <= w_br_next;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_d    <= w_res_next;
            r_bout <= w_br_next;
         end
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Operand sign bits are shifted out during RUN, so keep a copy for the overflow term.
   logic r_amsb;
   logic r_bmsb;
   logic r_ovf;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_amsb <= 1'b0;
         r_bmsb <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_load) begin
         r_amsb <= a[WIDTH-1];
         r_bmsb <= b[WIDTH-1];
      end else if ((r_state == StRun) && w_last) begin
         r_ovf <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_diff);
      end
   end

   assign ovf = r_ovf;
`endif

   assign busy = (r_state == StRun);
   assign done = (r_state == StDone);
   assign d    = r_d;
   assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub32.sv
// Scoreboard bench for serial_sub32 (WIDTH=32): driver pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_sub32;

   localparam int unsigned W = 32;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bout;
      logic         ovf;
   } exp_t;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   exp_t         q[$];
   int           vectors;
   int           miscompares;
   logic [W-1:0] last_d;
   logic         last_bout;

   serial_sub32 #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .d       (d),
      .bout    (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain modular / signed arithmetic.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   e;
      longint ud;
      longint sd;
      ud     = longint'({32'd0, x}) - longint'({32'd0, y});
      sd     = longint'($signed(x)) - longint'($signed(y));
      e.d    = ud[W-1:0];
      e.bout = (x < y);
      e.ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Called at a negedge; start is sampled at the next posedge.
   task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb);
      a     = xa;
      b     = xb;
      start = 1'b1;
      q.push_back(model(xa, xb));
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_done(input int k0, output int k);
      k = k0;
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (!reset_n) begin
         last_d    = '0;
         last_bout = 1'b0;
      end else if (done) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: d=%0h bout=%0b with no pending operation", d, bout);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (d !== e.d || bout !== e.bout || busy !== 1'b0
`ifdef SERIAL_SUB_OVF_EN
                || ovf !== e.ovf
`endif
               ) begin
               miscompares++;
               $display("FAIL result: d=%0h bout=%0b busy=%0b expected d=%0h bout=%0b busy=0",
                        d, bout, busy, e.d, e.bout);
`ifdef SERIAL_SUB_OVF_EN
               $display("  ovf=%0b expected %0b", ovf, e.ovf);
`endif
            end
            last_d    = e.d;
            last_bout = e.bout;
         end
      end else if (busy) begin
         vectors++;
         if (d !== last_d || bout !== last_bout) begin
            miscompares++;
            $display("FAIL hold_in_run: d=%0h bout=%0b expected d=%0h bout=%0b",
                     d, bout, last_d, last_bout);
         end
      end
   end

   initial begin
      int   k;
      logic bad;
      logic chain;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      start       = 1'b0;
      a           = '0;
      b           = '0;
      #1;
      check("reset_state", {busy, done, bout, d}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // 10 - 3 with full busy/done timing check
      issue(32'd10, 32'd3);
      bad = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         if (!busy || done) bad = 1'b1;
         if (i < 32) @(negedge clk);
      end
      check("busy_window", {63'd0, bad}, 64'd0);
      @(negedge clk);
      check("done_at_33", {62'd0, busy, done}, 64'd1);
      @(negedge clk);
      check("done_one_cycle", {62'd0, busy, done}, 64'd0);

      issue(32'd3, 32'd10);
      wait_done(1, k);
      check("latency_wrap", k, 33);
      @(negedge clk);
      issue(32'h8000_0000, 32'd1);
      wait_done(1, k);
      check("latency_ovf", k, 33);
      @(negedge clk);
      issue(32'd5, 32'd5);
      wait_done(1, k);
      check("latency_equal", k, 33);
      @(negedge clk);

      // Start during RUN ignored; start in DONE cycle restarts at once
      issue(32'd100, 32'd1);
      repeat (4) @(negedge clk);
      a     = '0;
      b     = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(6, k);
      check("latency_ignored_start", k, 33);
      issue(32'd1234, 32'd4321);
      check("busy_after_done_start", {63'd0, busy}, 64'd1);
      wait_done(1, k);
      check("latency_chained", k, 33);
      @(negedge clk);

      // Asynchronous reset mid-operation; abandoned op is never queued
      a     = 32'd50;
      b     = 32'd20;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", {busy, done, bout, d}, 64'd0);
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      issue(32'd1, 32'd2);
      wait_done(1, k);
      check("latency_after_reset", k, 33);
      @(negedge clk);

      // Start held high: back-to-back every 33 cycles
      a     = 32'd7;
      b     = 32'd2;
      start = 1'b1;
      q.push_back(model(32'd7, 32'd2));
      for (int n = 0; n < 3; n++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!done && k < 100);
         check("held_period", k, 33);
         if (n < 2) q.push_back(model(32'd7, 32'd2));
         else start = 1'b0;
      end
      @(negedge clk);

      // Randomized operations, some chained in the DONE cycle
      chain = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (!chain) repeat ($urandom_range(0, 3)) @(negedge clk);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = ra;
            1:       rb = 32'hFFFF_FFFF;
            2:       ra = 32'h8000_0000;
            3:       rb = 32'h8000_0000;
            default: ;
         endcase
         issue(ra, rb);
         wait_done(1, k);
         check("latency_random", k, 33);
         chain = 1'($urandom_range(0, 1));
         if (!chain) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_sub32.md
SERIAL_SUB32 -- requirements
Module: serial_sub32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to load operands and begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend.
REQ-007 The block SHALL have port busy, output, 1 bit: high while the FSM is in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port d, output, WIDTH bits: difference a-b modulo 2^WIDTH.
REQ-010 The block SHALL have port bout, output, 1 bit: final borrow, 1 when unsigned a < b.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE, encoded in 2 bits.
REQ-012 In IDLE or DONE, start=1 SHALL capture a and b into shift registers, clear the borrow flop and the bit counter, and go to RUN.
REQ-013 In RUN, start SHALL be ignored and the a/b inputs SHALL NOT be sampled.
REQ-014 Each RUN edge SHALL process one bit, LSB first: diff = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-015 On each RUN edge, both operand registers SHALL shift right by one bit, and diff SHALL shift into the MSB of the working result register.
REQ-016 The bit counter SHALL count 0..WIDTH-1; the edge that processes bit WIDTH-1 SHALL move the FSM to DONE.
REQ-017 The same edge SHALL copy the working result to d and the final borrow to bout.
REQ-018 Latency SHALL be exactly WIDTH edges from the start-sampling edge to the edge that enters DONE.
REQ-019 done SHALL be 1 only in DONE; DONE SHALL last one cycle and then go to IDLE, or to RUN if start=1 in that cycle.
REQ-020 d and bout SHALL hold their last value until the next completion and SHALL NOT change during RUN.
REQ-021 busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-022 A start held high continuously SHALL produce back-to-back operations, one every WIDTH+1 cycles.
REQ-023 Wrap-around: a<b SHALL give the two's-complement difference with bout=1; a=b SHALL give d=0 and bout=0.

Reset
REQ-024 reset_n=0 SHALL immediately, independent of clk, force IDLE and clear busy, done, d, bout, the counter, the borrow flop and all shift registers.
REQ-025 Reset asserted during RUN SHALL abandon the operation with no done pulse.
REQ-026 After reset_n rises, the first edge with start=1 SHALL begin a normal operation.

Configuration
REQ-027 With macro SERIAL_SUB_OVF_EN defined, the block SHALL add output ovf (1 bit), reset to 0, updated with d.
REQ-028 ovf SHALL equal (aMSB ^ bMSB) & (aMSB ^ dMSB), the signed overflow of the subtraction.
REQ-029 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification (WIDTH=32)
REQ-030 Drive a=10, b=3, start pulse -> busy for 32 cycles, done for 1 cycle 32 edges after the start edge, d=7, bout=0.
REQ-031 Drive a=3, b=10 -> d=0xFFFFFFF9, bout=1.
REQ-032 Drive a=0x80000000, b=1 with SERIAL_SUB_OVF_EN defined -> d=0x7FFFFFFF, bout=0, ovf=1; drive a=5, b=5 -> d=0, ovf=0.
REQ-033 Start with a=100, b=1, then a second start with a=0, b=0 at RUN cycle 5 -> second start ignored, d=99; an immediate start in the DONE cycle -> busy again on the next cycle.
REQ-034 Drive reset_n=0 at RUN cycle 10 -> busy=0, done=0, d=0 asynchronously, no done pulse; then a=1, b=2 -> d=0xFFFFFFFF, bout=1.
REQ-035 Drive start held high with a=7, b=2 -> done pulses every 33 cycles, d=5 each time.
